// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic array feed controller.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DRAIN
    } ctrl_state_e;

    localparam int unsigned DefRows         = 4;
    localparam int unsigned DefCols         = 4;
    localparam int unsigned DefVectorLength = 4;
    localparam int unsigned DefInputWidth   = 8;
    localparam int unsigned DefAccWidth     = 16;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Data+valid shift register of DEPTH+1 stages; DEPTH=0 is a single registered stage.
module skew_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_pending
);

    logic [WIDTH-1:0] r_data [DEPTH+1];
    logic [DEPTH:0]   r_valid;

    // Data only moves with its valid so an idle lane holds its last operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int j = 0; j <= int'(DEPTH); j++) begin
                r_data[j] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int j = 1; j <= int'(DEPTH); j++) begin
                r_valid[j] <= r_valid[j-1];
                if (r_valid[j-1]) begin
                    r_data[j] <= r_data[j-1];
                end
            end
        end
    end

    assign o_valid   = r_valid[DEPTH];
    assign o_data    = r_data[DEPTH];
    assign o_pending = |r_valid;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Tile sequencer for a systolic MAC array: clear, skewed operand feed, wait, row-major drain.
// Optional performance counters are enabled with SYSTOLIC_PERF_CNT_EN.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS          = DefRows,
    parameter int unsigned COLS          = DefCols,
    parameter int unsigned INPUT_WIDTH   = DefInputWidth,
    parameter int unsigned ACC_WIDTH     = DefAccWidth,
    parameter int unsigned VECTOR_LENGTH = DefVectorLength,
    localparam int unsigned KW = clog2_min1(VECTOR_LENGTH),
    localparam int unsigned RW = clog2_min1(ROWS),
    localparam int unsigned CW = clog2_min1(COLS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_a_rd_en,
    output logic [KW-1:0]                   o_a_rd_addr,
    input  logic [ROWS*INPUT_WIDTH-1:0]     i_a_rd_data,
    output logic                            o_b_rd_en,
    output logic [KW-1:0]                   o_b_rd_addr,
    input  logic [COLS*INPUT_WIDTH-1:0]     i_b_rd_data,
    output logic                            o_clear_out,
    output logic [ROWS*INPUT_WIDTH-1:0]     o_a_edge,
    output logic [ROWS-1:0]                 o_a_edge_valid,
    output logic [COLS*INPUT_WIDTH-1:0]     o_b_edge,
    output logic [COLS-1:0]                 o_b_edge_valid,
    input  logic [ROWS*COLS-1:0]            i_acc_valid_in,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0]  i_acc_value_in,
    output logic                            o_res_valid,
    input  logic                            i_res_ready,
    output logic [ACC_WIDTH-1:0]            o_res_data,
    output logic [RW-1:0]                   o_res_row,
`ifdef SYSTOLIC_PERF_CNT_EN
    output logic [CW-1:0]                   o_res_col,
    output logic [31:0]                     o_perf_busy_cycles,
    output logic [31:0]                     o_perf_stall_cycles
`else
    output logic [CW-1:0]                   o_res_col
`endif
);

    localparam int unsigned NumPe = ROWS * COLS;
    localparam int unsigned IW    = clog2_min1(NumPe);
    localparam logic [KW-1:0] KLast = KW'(VECTOR_LENGTH - 1);
    localparam logic [IW-1:0] ILast = IW'(NumPe - 1);

    ctrl_state_e   r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          r_done, w_done_nxt;
    logic          r_rd_valid;
    logic          w_rd_en, w_clear, w_res_valid, w_skew_busy;
    logic [ROWS-1:0] w_a_pending;
    logic [COLS-1:0] w_b_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_idx      <= w_idx_nxt;
            r_done     <= w_done_nxt;
            r_rd_valid <= w_rd_en;
        end
    end

    // The registered read valid counts as in flight so WAIT cannot exit early.
    assign w_skew_busy = r_rd_valid | (|w_a_pending) | (|w_b_pending);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_clear     = 1'b0;
        w_rd_en     = 1'b0;
        w_res_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (i_start && !r_done) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_clear     = 1'b1;
                w_k_nxt     = '0;
                w_state_nxt = FEED;
            end
            FEED: begin
                w_rd_en = 1'b1;
                if (r_k == KLast) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            WAIT: begin
                if ((&i_acc_valid_in) && !w_skew_busy) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_res_valid = 1'b1;
                if (i_res_ready) begin
                    if (r_idx == ILast) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        skew_delay_line #(
            .WIDTH (INPUT_WIDTH),
            .DEPTH (r)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (r_rd_valid),
            .i_data    (i_a_rd_data[r*INPUT_WIDTH +: INPUT_WIDTH]),
            .o_valid   (o_a_edge_valid[r]),
            .o_data    (o_a_edge[r*INPUT_WIDTH +: INPUT_WIDTH]),
            .o_pending (w_a_pending[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        skew_delay_line #(
            .WIDTH (INPUT_WIDTH),
            .DEPTH (c)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (r_rd_valid),
            .i_data    (i_b_rd_data[c*INPUT_WIDTH +: INPUT_WIDTH]),
            .o_valid   (o_b_edge_valid[c]),
            .o_data    (o_b_edge[c*INPUT_WIDTH +: INPUT_WIDTH]),
            .o_pending (w_b_pending[c])
        );
    end

    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_clear_out = w_clear;
    assign o_a_rd_en   = w_rd_en;
    assign o_b_rd_en   = w_rd_en;
    assign o_a_rd_addr = w_rd_en ? r_k : '0;
    assign o_b_rd_addr = w_rd_en ? r_k : '0;
    assign o_res_valid = w_res_valid;
    assign o_res_data  = w_res_valid ? i_acc_value_in[r_idx*ACC_WIDTH +: ACC_WIDTH] : '0;
    assign o_res_row   = w_res_valid ? RW'(r_idx / COLS) : '0;
    assign o_res_col   = w_res_valid ? CW'(r_idx % COLS) : '0;

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (o_busy && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + 1'b1;
            end
            if (w_res_valid && !i_res_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign o_perf_busy_cycles  = r_perf_busy;
    assign o_perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench: operand buffers, ideal array model and per-tile scoreboard.
module tb_systolic_feed_ctrl;

    localparam int R   = 4;
    localparam int C   = 4;
    localparam int K   = 4;
    localparam int IWD = 8;
    localparam int AW  = 16;
    // WAIT lasts: read return + first skew stage + (widest lane skew) + model capture.
    localparam int WAITC = 3 + ((R > C ? R : C) - 1);
    localparam int LAT   = 1 + K + WAITC + R * C + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              i_start, i_res_ready;
    logic              o_busy, o_done, o_a_rd_en, o_b_rd_en, o_clear_out, o_res_valid;
    logic [1:0]        o_a_rd_addr, o_b_rd_addr, o_res_row, o_res_col;
    logic [R*IWD-1:0]  a_rd_data, o_a_edge;
    logic [C*IWD-1:0]  b_rd_data, o_b_edge;
    logic [R-1:0]      o_a_edge_valid;
    logic [C-1:0]      o_b_edge_valid;
    logic [R*C-1:0]    acc_valid, stall_mask;
    logic [R*C*AW-1:0] acc_value;
    logic [AW-1:0]     o_res_data;

    systolic_feed_ctrl #(
        .ROWS(R), .COLS(C), .INPUT_WIDTH(IWD), .ACC_WIDTH(AW), .VECTOR_LENGTH(K)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_a_rd_en      (o_a_rd_en),
        .o_a_rd_addr    (o_a_rd_addr),
        .i_a_rd_data    (a_rd_data),
        .o_b_rd_en      (o_b_rd_en),
        .o_b_rd_addr    (o_b_rd_addr),
        .i_b_rd_data    (b_rd_data),
        .o_clear_out    (o_clear_out),
        .o_a_edge       (o_a_edge),
        .o_a_edge_valid (o_a_edge_valid),
        .o_b_edge       (o_b_edge),
        .o_b_edge_valid (o_b_edge_valid),
        .i_acc_valid_in (acc_valid),
        .i_acc_value_in (acc_value),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready),
        .o_res_data     (o_res_data),
        .o_res_row      (o_res_row),
        .o_res_col      (o_res_col)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffers with one-cycle read latency.
    logic [IWD-1:0] mem_a [R][K];
    logic [IWD-1:0] mem_b [K][C];
    always @(posedge clk) begin
        if (o_a_rd_en) for (int r = 0; r < R; r++) a_rd_data[r*IWD +: IWD] <= mem_a[r][o_a_rd_addr];
        if (o_b_rd_en) for (int c = 0; c < C; c++) b_rd_data[c*IWD +: IWD] <= mem_b[o_b_rd_addr][c];
    end

    // Ideal array: a PE is done once its row and column lanes each delivered K operands.
    logic [IWD-1:0] a_cap [R][K];
    logic [IWD-1:0] b_cap [K][C];
    int a_cnt [R];
    int b_cnt [C];
    always @(posedge clk) begin
        for (int r = 0; r < R; r++) begin
            if (rst || o_clear_out) a_cnt[r] <= 0;
            else if (o_a_edge_valid[r] && a_cnt[r] < K) begin
                a_cap[r][a_cnt[r]] <= o_a_edge[r*IWD +: IWD];
                a_cnt[r] <= a_cnt[r] + 1;
            end
        end
        for (int c = 0; c < C; c++) begin
            if (rst || o_clear_out) b_cnt[c] <= 0;
            else if (o_b_edge_valid[c] && b_cnt[c] < K) begin
                b_cap[b_cnt[c]][c] <= o_b_edge[c*IWD +: IWD];
                b_cnt[c] <= b_cnt[c] + 1;
            end
        end
    end

    always_comb begin
        logic [31:0] sum;
        acc_value = '0;
        acc_valid = '0;
        sum = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                sum = '0;
                for (int k = 0; k < K; k++) sum = sum + a_cap[r][k] * b_cap[k][c];
                acc_value[(r*C+c)*AW +: AW] = sum[AW-1:0];
                acc_valid[r*C+c] = (a_cnt[r] == K) && (b_cnt[c] == K) && !stall_mask[r*C+c];
            end
        end
    end

    function automatic logic [AW-1:0] exp_c(input int r, input int c);
        logic [31:0] s = 0;
        for (int k = 0; k < K; k++) s = s + mem_a[r][k] * mem_b[k][c];
        return s[AW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_clear", 32'(o_clear_out), 0);
        chk("rst_rd_en", 32'({o_a_rd_en, o_b_rd_en}), 0);
        chk("rst_rd_addr", 32'({o_a_rd_addr, o_b_rd_addr}), 0);
        chk("rst_edge_valid", 32'({o_a_edge_valid, o_b_edge_valid}), 0);
        chk("rst_edge_data", 32'(o_a_edge) | 32'(o_b_edge), 0);
        chk("rst_res_valid", 32'(o_res_valid), 0);
        chk("rst_res_fields", {14'd0, o_res_data, o_res_row, o_res_col}, 0);
    endtask

    task automatic load_rand();
        for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) mem_a[r][k] = IWD'($urandom_range(0, 255));
        for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) mem_b[k][c] = IWD'($urandom_range(0, 255));
    endtask

    // ready_mode 0: always ready; 1: repeating 1,0,0,1. stall_pe >= 0 masks that PE's acc_valid.
    task automatic run_tile(input int ready_mode, input int stall_pe, input bit hold_start,
                            output int t_done);
        int n = 0, clear_cnt = 0, t_clear = -1, t_rd = -1, hold = 0, hold_bad = 0;
        int t_rel = -1, t_res = -1, got_done = 0;
        int a_first [R], a_last [R], a_n [R], b_first [C], b_last [C], b_n [C];
        bit pv_stall = 0, lanes_done;
        logic [AW-1:0] pv_data = '0;
        logic [1:0] pv_row = '0, pv_col = '0;
        t_done = -1;
        for (int r = 0; r < R; r++) begin a_first[r] = -1; a_last[r] = -1; a_n[r] = 0; end
        for (int c = 0; c < C; c++) begin b_first[c] = -1; b_last[c] = -1; b_n[c] = 0; end
        stall_mask = '0;
        if (stall_pe >= 0) stall_mask[stall_pe] = 1'b1;
        i_start = 1'b1;
        for (int step = 0; step < 3000 && got_done == 0; step++) begin
            @(negedge clk);
            i_res_ready = (ready_mode == 0) ? 1'b1 : ((step % 4 == 0) || (step % 4 == 3));
            if (o_clear_out) begin clear_cnt++; t_clear = cyc; end
            if (o_a_rd_en && t_rd < 0) t_rd = cyc;
            for (int r = 0; r < R; r++) if (o_a_edge_valid[r]) begin
                if (a_first[r] < 0) a_first[r] = cyc;
                a_last[r] = cyc; a_n[r]++;
            end
            for (int c = 0; c < C; c++) if (o_b_edge_valid[c]) begin
                if (b_first[c] < 0) b_first[c] = cyc;
                b_last[c] = cyc; b_n[c]++;
            end
            if (pv_stall) begin
                chk("stall_valid", 32'(o_res_valid), 1);
                chk("stall_data", 32'(o_res_data), 32'(pv_data));
                chk("stall_rowcol", 32'({o_res_row, o_res_col}), 32'({pv_row, pv_col}));
            end
            if (o_res_valid && t_res < 0) t_res = cyc;
            if (o_res_valid && i_res_ready) begin
                chk("res_row", 32'(o_res_row), n / C);
                chk("res_col", 32'(o_res_col), n % C);
                chk("res_data", 32'(o_res_data), 32'(exp_c(n / C, n % C)));
                n++;
            end
            pv_stall = o_res_valid && !i_res_ready;
            pv_data = o_res_data; pv_row = o_res_row; pv_col = o_res_col;
            lanes_done = 1;
            for (int r = 0; r < R; r++) if (a_n[r] != K) lanes_done = 0;
            for (int c = 0; c < C; c++) if (b_n[c] != K) lanes_done = 0;
            if (stall_mask != '0 && lanes_done) begin
                hold++;
                if (o_res_valid || !o_busy) hold_bad++;
                if (hold == 50) begin stall_mask = '0; t_rel = cyc; end
            end
            if (o_done) begin got_done = 1; t_done = cyc; end
            if (!hold_start && clear_cnt > 0) i_start = 1'b0;
        end
        chk("done_seen", got_done, 1);
        chk("n_results", n, R * C);
        chk("clear_once", clear_cnt, 1);
        chk("clear_to_rd", t_rd - t_clear, 1);
        chk("a_lane0_lat", a_first[0] - t_rd, 2);
        for (int r = 0; r < R; r++) begin
            chk("a_lane_len", a_n[r], K);
            chk("a_lane_span", a_last[r] - a_first[r] + 1, K);
            chk("a_lane_skew", a_first[r] - a_first[0], r);
        end
        for (int c = 0; c < C; c++) begin
            chk("b_lane_len", b_n[c], K);
            chk("b_lane_span", b_last[c] - b_first[c] + 1, K);
            chk("b_lane_skew", b_first[c] - b_first[0], c);
        end
        if (stall_pe >= 0) begin
            chk("wait_hold_len", hold, 50);
            chk("wait_hold_bad", hold_bad, 0);
            chk("wait_release", t_res - t_rel, 1);
        end else if (ready_mode == 0) begin
            chk("tile_latency", t_done - (t_clear - 1), LAT);
        end
        if (!hold_start) i_start = 1'b0;
    endtask

    initial begin
        int td, t1, t2, found, noisy;
        i_start = 1'b0;
        i_res_ready = 1'b1;
        stall_mask = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        // Identity A, B[k][c] = 10k+c gives C[r][c] = 10r+c.
        for (int r = 0; r < R; r++) for (int k = 0; k < K; k++) mem_a[r][k] = (r == k) ? 8'd1 : 8'd0;
        for (int k = 0; k < K; k++) for (int c = 0; c < C; c++) mem_b[k][c] = IWD'(10 * k + c);
        run_tile(0, -1, 0, td);

        load_rand();
        run_tile(1, -1, 0, td);

        load_rand();
        run_tile(0, 5, 0, td);

        // Abort during FEED at k=2.
        load_rand();
        i_start = 1'b1;
        found = 0;
        for (int s = 0; s < 50 && found == 0; s++) begin
            @(negedge clk);
            if (o_a_rd_en && o_a_rd_addr == 2'd2) found = 1;
        end
        chk("abort_reach_k2", found, 1);
        i_start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        noisy = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done || o_busy) noisy++;
        end
        chk("abort_quiet", noisy, 0);
        load_rand();
        run_tile(0, -1, 0, td);

        // start held high: back-to-back tiles.
        load_rand();
        run_tile(0, -1, 1, t1);
        load_rand();
        run_tile(0, -1, 1, t2);
        chk("b2b_gap", t2 - t1, LAT + 1);
        load_rand();
        run_tile(0, -1, 1, td);
        chk("b2b_gap", td - t2, LAT + 1);
        i_start = 1'b0;

        repeat (3) @(negedge clk);
        chk("idle_after", 32'(o_busy), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
